// File: rtl/game_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_defs_pkg
// Description : Shared definitions for the two-player spy game: state codes,
//               default turn/round settings and the 1 Hz divider constant.
// Revision    : 1.0 - initial release
// ============================================================================
package game_defs_pkg;

  // State codes shown on the hex display, so their values are fixed.
  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_P1TURN   = 3'd1,
    S_P2TURN   = 3'd2,
    S_RESULT   = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam int DEF_TURN_SECONDS = 10;
  localparam int DEF_ROUNDS       = 3;

  // CLOCK_50 cycles per second; callers of rate_divider use this for the tick.
  localparam int ONE_HZ_DIV       = 50_000_000;

endpackage : game_defs_pkg
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : 1-bit rising-edge detector. History resets to 1 so a key held
//               down through reset does not produce a spurious pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic pulse_o
);

  logic hist_q;

  // Remember last cycle's key level.
  always_ff @(posedge clock) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= d_i;
  end

  assign pulse_o = d_i & ~hist_q;

endmodule : key_edge
`default_nettype wire

// File: rtl/turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : turn_scheduler
// Description : Game sequencer: start -> player-1 entry -> player-2 guess ->
//               result -> next round / game over. Runs the per-turn countdown
//               from the 1 Hz tick and keeps both players' scores.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_scheduler
  import game_defs_pkg::*;
#(
  parameter int TURN_SECONDS = DEF_TURN_SECONDS,
  parameter int ROUNDS       = DEF_ROUNDS,
  parameter int SCORE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               done_i,
  input  logic               correct_i,
  output logic               p1_en_o,
  output logic               p2_en_o,
  output logic [2:0]         state_o,
  output logic [3:0]         time_left_o,
  output logic [1:0]         round_o,
  output logic [SCORE_W-1:0] p1_score_o,
  output logic [SCORE_W-1:0] p2_score_o,
  output logic               timeout_o,
  output logic               game_over_o
);

  localparam logic [3:0]         TURN_LOAD  = 4'(TURN_SECONDS);
  localparam logic [1:0]         LAST_ROUND = 2'(ROUNDS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic start_p;
  logic done_p;

  state_t             state_q,     state_d;
  logic [3:0]         time_q,      time_d;
  logic [1:0]         round_q,     round_d;
  logic [SCORE_W-1:0] p1_score_q,  p1_score_d;
  logic [SCORE_W-1:0] p2_score_q,  p2_score_d;
  logic               timeout_q,   timeout_d;
  logic               p1_en_q,     p1_en_d;
  logic               p2_en_q,     p2_en_d;
  logic               game_over_q, game_over_d;

  key_edge u_start_edge (
    .clock   (clock),
    .reset   (reset),
    .d_i     (start_i),
    .pulse_o (start_p)
  );

  key_edge u_done_edge (
    .clock   (clock),
    .reset   (reset),
    .d_i     (done_i),
    .pulse_o (done_p)
  );

  // State and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_START;
      time_q      <= TURN_LOAD;
      round_q     <= 2'd0;
      p1_score_q  <= '0;
      p2_score_q  <= '0;
      timeout_q   <= 1'b0;
      p1_en_q     <= 1'b0;
      p2_en_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      round_q     <= round_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      timeout_q   <= timeout_d;
      p1_en_q     <= p1_en_d;
      p2_en_q     <= p2_en_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state, countdown, round and score logic.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    round_d    = round_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_START: begin
        if (start_p) begin
          state_d    = S_P1TURN;
          round_d    = 2'd0;
          p1_score_d = '0;
          p2_score_d = '0;
          time_d     = TURN_LOAD;
          timeout_d  = 1'b0;
        end
      end

      S_P1TURN, S_P2TURN: begin
        // A done press beats a simultaneous expiry.
        if (done_p) begin
          state_d   = (state_q == S_P1TURN) ? S_P2TURN : S_RESULT;
          time_d    = TURN_LOAD;
          timeout_d = 1'b0;
        end else if (tick_i) begin
          if (time_q <= 4'd1) begin
            state_d   = (state_q == S_P1TURN) ? S_P2TURN : S_RESULT;
            time_d    = TURN_LOAD;
            timeout_d = 1'b1;
          end else begin
            time_d = time_q - 4'd1;
          end
        end
      end

      S_RESULT: begin
        // An expired guess counts as a miss regardless of the match flag.
        if (correct_i && !timeout_q) begin
          if (p2_score_q != SCORE_MAX) p2_score_d = p2_score_q + 1'b1;
        end else begin
          if (p1_score_q != SCORE_MAX) p1_score_d = p1_score_q + 1'b1;
        end
        if (round_q == LAST_ROUND) begin
          state_d = S_GAMEOVER;
        end else begin
          state_d   = S_P1TURN;
          round_d   = round_q + 2'd1;
          time_d    = TURN_LOAD;
          timeout_d = 1'b0;
        end
      end

      S_GAMEOVER: begin
        if (start_p) state_d = S_START;
      end

      default: state_d = S_START;
    endcase

    p1_en_d     = (state_d == S_P1TURN);
    p2_en_d     = (state_d == S_P2TURN);
    game_over_d = (state_d == S_GAMEOVER);
  end

  assign p1_en_o     = p1_en_q;
  assign p2_en_o     = p2_en_q;
  assign state_o     = state_q;
  assign time_left_o = time_q;
  assign round_o     = round_q;
  assign p1_score_o  = p1_score_q;
  assign p2_score_o  = p2_score_q;
  assign timeout_o   = timeout_q;
  assign game_over_o = game_over_q;

endmodule : turn_scheduler
`default_nettype wire

// File: tb/tb_turn_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_scheduler
// Description : Self-checking bench for turn_scheduler: directed scenarios plus
//               randomized full games scored by a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_scheduler;

  localparam int TS = 10;
  localparam int NR = 3;
  localparam int SW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, start = 1'b0, done = 1'b0, correct = 1'b0;
  logic p1_en, p2_en, timeout, game_over;
  logic [2:0] st;
  logic [3:0] tl;
  logic [1:0] rnd;
  logic [SW-1:0] p1s, p2s;

  int n_pass  = 0;
  int n_total = 0;

  turn_scheduler #(.TURN_SECONDS(TS), .ROUNDS(NR), .SCORE_W(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick_i      (tick),
    .start_i     (start),
    .done_i      (done),
    .correct_i   (correct),
    .p1_en_o     (p1_en),
    .p2_en_o     (p2_en),
    .state_o     (st),
    .time_left_o (tl),
    .round_o     (rnd),
    .p1_score_o  (p1s),
    .p2_score_o  (p2s),
    .timeout_o   (timeout),
    .game_over_o (game_over)
  );

  always #5 clock = ~clock;

  // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
  endtask

  // One low cycle first so the key history sees a fresh rising edge.
  task automatic press_start();
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic press_done();
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    cyc(2);
    reset = 1'b0;
    n_total++; if (st !== 3'd0) $display("FAIL reset_state got %0d want 0", st); else n_pass++;
    n_total++; if (tl !== 4'(TS)) $display("FAIL reset_time_left got %0d want %0d", tl, TS); else n_pass++;
    n_total++; if ({p1_en, p2_en, timeout, game_over} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {p1_en, p2_en, timeout, game_over}); else n_pass++;
    n_total++; if ({rnd, p1s, p2s} !== '0) $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", rnd, p1s, p2s); else n_pass++;
    cyc(3);
    n_total++; if (st !== 3'd0) $display("FAIL held_start_no_fire got %0d want 0", st); else n_pass++;
    start = 1'b0;
    press_start();
    n_total++; if (st !== 3'd1 || p1_en !== 1'b1 || p2_en !== 1'b0) $display("FAIL start_to_p1 got st=%0d p1_en=%b p2_en=%b want 1/1/0", st, p1_en, p2_en); else n_pass++;
  endtask

  task automatic test_p1_done_p2_done();
    correct = 1'b0;
    tick_n(3);
    n_total++; if (tl !== 4'(TS - 3)) $display("FAIL p1_countdown got %0d want %0d", tl, TS - 3); else n_pass++;
    press_done();
    n_total++; if (st !== 3'd2 || tl !== 4'(TS) || timeout !== 1'b0 || p2_en !== 1'b1 || p1_en !== 1'b0)
      $display("FAIL p1_done got st=%0d tl=%0d to=%b en=%b%b want 2/%0d/0/01", st, tl, timeout, p1_en, p2_en, TS); else n_pass++;
    press_done();
    n_total++; if (st !== 3'd3 || p1_en !== 1'b0 || p2_en !== 1'b0) $display("FAIL p2_done_result got st=%0d en=%b%b want 3/00", st, p1_en, p2_en); else n_pass++;
    cyc(1);
    n_total++; if (st !== 3'd1 || rnd !== 2'd1 || tl !== 4'(TS)) $display("FAIL next_round got st=%0d rnd=%0d tl=%0d want 1/1/%0d", st, rnd, tl, TS); else n_pass++;
    n_total++; if (p1s !== 4'd1 || p2s !== 4'd0) $display("FAIL wrong_guess_score got %0d/%0d want 1/0", p1s, p2s); else n_pass++;
  endtask

  task automatic test_p2_timeout();
    press_done();
    correct = 1'b1;
    tick_n(TS - 1);
    n_total++; if (st !== 3'd2 || tl !== 4'd1) $display("FAIL p2_no_underflow got st=%0d tl=%0d want 2/1", st, tl); else n_pass++;
    tick_n(1);
    n_total++; if (st !== 3'd3 || timeout !== 1'b1) $display("FAIL p2_expiry got st=%0d to=%b want 3/1", st, timeout); else n_pass++;
    cyc(1);
    n_total++; if (p1s !== 4'd2 || p2s !== 4'd0) $display("FAIL timeout_score got %0d/%0d want 2/0", p1s, p2s); else n_pass++;
    n_total++; if (st !== 3'd1 || rnd !== 2'd2 || timeout !== 1'b0) $display("FAIL timeout_next_round got st=%0d rnd=%0d to=%b want 1/2/0", st, rnd, timeout); else n_pass++;
  endtask

  task automatic test_finish_game();
    press_done();
    correct = 1'b1;
    press_done();
    n_total++; if (st !== 3'd3) $display("FAIL last_result got %0d want 3", st); else n_pass++;
    cyc(1);
    n_total++; if (st !== 3'd4 || game_over !== 1'b1 || p1_en !== 1'b0 || p2_en !== 1'b0) $display("FAIL gameover got st=%0d go=%b want 4/1", st, game_over); else n_pass++;
    n_total++; if (p1s !== 4'd2 || p2s !== 4'd1 || rnd !== 2'd2) $display("FAIL final_score got %0d/%0d rnd=%0d want 2/1/2", p1s, p2s, rnd); else n_pass++;
  endtask

  task automatic test_gameover();
    tick_n(2);
    press_done();
    n_total++; if (st !== 3'd4 || p1s !== 4'd2 || p2s !== 4'd1) $display("FAIL gameover_hold got st=%0d %0d/%0d want 4/2/1", st, p1s, p2s); else n_pass++;
    press_start();
    n_total++; if (st !== 3'd0 || game_over !== 1'b0 || p1s !== 4'd2) $display("FAIL gameover_to_start got st=%0d go=%b p1=%0d want 0/0/2", st, game_over, p1s); else n_pass++;
    press_start();
    n_total++; if (st !== 3'd1 || p1s !== 4'd0 || p2s !== 4'd0 || rnd !== 2'd0) $display("FAIL new_game_clear got st=%0d %0d/%0d rnd=%0d want 1/0/0/0", st, p1s, p2s, rnd); else n_pass++;
  endtask

  task automatic test_done_tick_same();
    tick_n(TS - 1);
    press_start();
    n_total++; if (st !== 3'd1 || tl !== 4'd1) $display("FAIL start_ignored_in_turn got st=%0d tl=%0d want 1/1", st, tl); else n_pass++;
    cyc(1);
    tick = 1'b1; done = 1'b1;
    cyc(1);
    tick = 1'b0; done = 1'b0;
    n_total++; if (st !== 3'd2 || timeout !== 1'b0 || tl !== 4'(TS)) $display("FAIL done_beats_expiry got st=%0d to=%b tl=%0d want 2/0/%0d", st, timeout, tl, TS); else n_pass++;
    correct = 1'b1;
    tick_n(TS);
    cyc(1);
    n_total++; if (p1s !== 4'd1 || p2s !== 4'd0 || rnd !== 2'd1) $display("FAIL expiry_overrides_correct got %0d/%0d rnd=%0d want 1/0/1", p1s, p2s, rnd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    press_done();
    n_total++; if (st !== 3'd2 || p2_en !== 1'b1) $display("FAIL mid_setup got st=%0d p2_en=%b want 2/1", st, p2_en); else n_pass++;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    n_total++; if (st !== 3'd0 || p2_en !== 1'b0 || rnd !== 2'd0 || p1s !== 4'd0 || p2s !== 4'd0 || tl !== 4'(TS))
      $display("FAIL reset_mid got st=%0d p2_en=%b rnd=%0d %0d/%0d tl=%0d want 0/0/0/0/0/%0d", st, p2_en, rnd, p1s, p2s, tl, TS); else n_pass++;
    tick_n(3);
    press_done();
    n_total++; if (st !== 3'd0 || tl !== 4'(TS)) $display("FAIL start_ignores_tick_done got st=%0d tl=%0d want 0/%0d", st, tl, TS); else n_pass++;
  endtask

  // Randomized games; the model only tracks how each guess turn ended.
  task automatic test_random_games();
    int k, c, e1, e2, exp_p1, exp_p2;
    for (int g = 0; g < 3; g++) begin
      press_start();
      exp_p1 = 0; exp_p2 = 0;
      for (int r = 0; r < NR; r++) begin
        k = $urandom_range(0, TS);
        if (k == TS) begin
          tick_n(TS);
          e1 = 1;
        end else begin
          tick_n(k);
          n_total++; if (tl !== 4'(TS - k)) $display("FAIL rand_p1_time g%0d r%0d got %0d want %0d", g, r, tl, TS - k); else n_pass++;
          press_done();
          e1 = 0;
        end
        n_total++; if (st !== 3'd2 || timeout !== 1'(e1)) $display("FAIL rand_p1_end g%0d r%0d got st=%0d to=%b want 2/%0d", g, r, st, timeout, e1); else n_pass++;
        k = $urandom_range(0, TS);
        c = $urandom_range(0, 1);
        correct = 1'(c);
        if (k == TS) begin
          tick_n(TS);
          e2 = 1;
        end else begin
          tick_n(k);
          press_done();
          e2 = 0;
        end
        n_total++; if (st !== 3'd3 || timeout !== 1'(e2)) $display("FAIL rand_p2_end g%0d r%0d got st=%0d to=%b want 3/%0d", g, r, st, timeout, e2); else n_pass++;
        if (c == 1 && e2 == 0) exp_p2++; else exp_p1++;
        cyc(1);
        if (r == NR - 1) begin
          n_total++; if (st !== 3'd4 || game_over !== 1'b1) $display("FAIL rand_gameover g%0d got st=%0d go=%b want 4/1", g, st, game_over); else n_pass++;
        end else begin
          n_total++; if (st !== 3'd1 || rnd !== 2'(r + 1)) $display("FAIL rand_round g%0d r%0d got st=%0d rnd=%0d want 1/%0d", g, r, st, rnd, r + 1); else n_pass++;
        end
      end
      n_total++; if (p1s !== SW'(exp_p1) || p2s !== SW'(exp_p2)) $display("FAIL rand_score g%0d got %0d/%0d want %0d/%0d", g, p1s, p2s, exp_p1, exp_p2); else n_pass++;
      press_start();
    end
  endtask

  initial begin
    test_reset();
    test_p1_done_p2_done();
    test_p2_timeout();
    test_finish_game();
    test_gameover();
    test_done_tick_same();
    test_reset_mid();
    test_random_games();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_turn_scheduler
`default_nettype wire
